uart_cat_cmd: RTL

Byte-stream command decoder sitting between the UART RX FIFO and the cat LED logic. It pops received bytes through a FIFO read handshake and maintains the 8-bit `cat_status` register. Status reads are answered through the UART TX FIFO. It replaces the direct sampling of `rx_out[7:0]` with a proper pop-per-byte consumer, so repeated identical bytes are each acted on once.

---
 rtl/uart_cat_cmd_pkg.sv | 28 ++
 rtl/uart_cat_cmd_if.sv | 19 +
 rtl/uart_cat_cmd_hex_ascii.sv | 30 +++
 rtl/uart_cat_cmd.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/uart_cat_cmd_pkg.sv
// rtl/uart_cat_cmd_pkg.sv - shared states, ASCII codes and timeout helper for the cat command decoder
package cat_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEX_HI,
        ST_HEX_LO,
        ST_TX_HI,
        ST_TX_LO,
        ST_TX_NL
    } state_e;

    localparam logic [7:0] ASCII_UC_A  = 8'h41;
    localparam logic [7:0] ASCII_UC_H  = 8'h48;
    localparam logic [7:0] ASCII_LC_A  = 8'h61;
    localparam logic [7:0] ASCII_LC_H  = 8'h68;
    localparam logic [7:0] ASCII_BTICK = 8'h60;
    localparam logic [7:0] ASCII_HASH  = 8'h23;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SP    = 8'h20;

    function automatic int TIMEOUT_CYCLES(input int clk_freq, input int timeout_ms);
        return (clk_freq / 1000) * timeout_ms;
    endfunction

endpackage

// File: rtl/uart_cat_cmd_if.sv
// rtl/uart_cat_cmd_if.sv - RX/TX FIFO handshake bundle between the decoder and the UART FIFOs
interface uart_cat_cmd_if;
    logic       rx_empty;
    logic [7:0] rx_data;
    logic       rx_rd;
    logic       tx_full;
    logic [7:0] tx_data;
    logic       tx_wr;

    modport master (
        input  rx_empty, rx_data, tx_full,
        output rx_rd, tx_data, tx_wr
    );

    modport slave (
        output rx_empty, rx_data, tx_full,
        input  rx_rd, tx_data, tx_wr
    );
endinterface

// File: rtl/uart_cat_cmd_hex_ascii.sv
// rtl/uart_cat_cmd_hex_ascii.sv - combinational hex digit decode (ENCODE=0) or nibble-to-uppercase-ASCII encode (ENCODE=1)
module hex_ascii #(
    parameter bit ENCODE = 1'b0
) (
    input  logic [7:0] in_i,
    output logic [7:0] out_o,
    output logic       valid_o
);
    always_comb begin
        out_o   = 8'h00;
        valid_o = 1'b0;
        if (ENCODE) begin
            // Encode flags inputs that carry more than a nibble.
            valid_o = (in_i[7:4] == 4'h0);
            out_o   = (in_i[3:0] < 4'd10) ? (8'h30 + {4'h0, in_i[3:0]})
                                          : (8'h37 + {4'h0, in_i[3:0]});
        end else begin
            if (in_i >= 8'h30 && in_i <= 8'h39) begin
                valid_o = 1'b1;
                out_o   = in_i - 8'h30;
            end else if (in_i >= 8'h41 && in_i <= 8'h46) begin
                valid_o = 1'b1;
                out_o   = in_i - 8'h37;
            end else if (in_i >= 8'h61 && in_i <= 8'h66) begin
                valid_o = 1'b1;
                out_o   = in_i - 8'h57;
            end
        end
    end
endmodule

// File: rtl/uart_cat_cmd.sv
// rtl/uart_cat_cmd.sv - pop-per-byte command decoder maintaining cat_status and answering status reads
module uart_cat_cmd
    import cat_cmd_pkg::*;
#(
    parameter int CLK_FREQ   = 103_340_000,
    parameter int TIMEOUT_MS = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_cat_cmd_if.master        fifo,
    output logic [7:0]            cat_status,
    output logic                  cmd_err
);
    localparam int TO_CYC = TIMEOUT_CYCLES(CLK_FREQ, TIMEOUT_MS);
    localparam int CW     = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);

    state_e        state_q, state_d;
    logic [7:0]    cat_q, cat_d;
    logic [7:0]    hi_q, hi_d;
    logic [7:0]    snap_q, snap_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          rd_prev_q;

    logic [7:0] dec_val, enc_hi_char, enc_lo_char;
    logic       dec_valid, enc_hi_valid, enc_lo_valid;
    logic [7:0] off_uc, off_lc;
    logic       rd_ok;

    hex_ascii #(.ENCODE(1'b0)) u_dec (
        .in_i(fifo.rx_data), .out_o(dec_val), .valid_o(dec_valid)
    );
    hex_ascii #(.ENCODE(1'b1)) u_enc_hi (
        .in_i({4'h0, snap_q[7:4]}), .out_o(enc_hi_char), .valid_o(enc_hi_valid)
    );
    hex_ascii #(.ENCODE(1'b1)) u_enc_lo (
        .in_i({4'h0, snap_q[3:0]}), .out_o(enc_lo_char), .valid_o(enc_lo_valid)
    );

    assign off_uc = fifo.rx_data - ASCII_UC_A;
    assign off_lc = fifo.rx_data - ASCII_LC_A;
    // The gap cycle after every pop gives the FIFO time to present its next head.
    assign rd_ok  = !fifo.rx_empty && !rd_prev_q;

    assign cat_status = cat_q;
    assign cmd_err    = err_q;

    always_comb begin
        state_d      = state_q;
        cat_d        = cat_q;
        hi_d         = hi_q;
        snap_d       = snap_q;
        cnt_d        = cnt_q;
        err_d        = 1'b0;
        fifo.rx_rd   = 1'b0;
        fifo.tx_wr   = 1'b0;
        fifo.tx_data = 8'h00;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (rd_ok) begin
                    fifo.rx_rd = 1'b1;
                    if (fifo.rx_data >= ASCII_UC_A && fifo.rx_data <= ASCII_UC_H) begin
                        cat_d[off_uc[2:0]] = 1'b0;
                    end else if (fifo.rx_data >= ASCII_LC_A && fifo.rx_data <= ASCII_LC_H) begin
                        cat_d[off_lc[2:0]] = 1'b1;
                    end else if (fifo.rx_data == ASCII_BTICK) begin
                        cat_d = 8'hFF;
                    end else if (fifo.rx_data == ASCII_HASH) begin
                        state_d = ST_HEX_HI;
                    end else if (fifo.rx_data == ASCII_QMARK) begin
                        snap_d  = cat_q;
                        state_d = ST_TX_HI;
                    end else if (fifo.rx_data != ASCII_LF && fifo.rx_data != ASCII_CR &&
                                 fifo.rx_data != ASCII_SP) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_HEX_HI, ST_HEX_LO: begin
                // A pop in the expiry cycle takes priority over the timeout.
                if (rd_ok) begin
                    fifo.rx_rd = 1'b1;
                    cnt_d      = '0;
                    if (!dec_valid) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (state_q == ST_HEX_HI) begin
                        hi_d    = dec_val;
                        state_d = ST_HEX_LO;
                    end else begin
                        cat_d   = (hi_q << 4) | dec_val;
                        state_d = ST_IDLE;
                    end
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_TX_HI: begin
                fifo.tx_wr   = !fifo.tx_full;
                fifo.tx_data = enc_hi_valid ? enc_hi_char : 8'h00;
                if (!fifo.tx_full) state_d = ST_TX_LO;
            end
            ST_TX_LO: begin
                fifo.tx_wr   = !fifo.tx_full;
                fifo.tx_data = enc_lo_valid ? enc_lo_char : 8'h00;
                if (!fifo.tx_full) state_d = ST_TX_NL;
            end
            ST_TX_NL: begin
                fifo.tx_wr   = !fifo.tx_full;
                fifo.tx_data = ASCII_LF;
                if (!fifo.tx_full) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cat_q     <= 8'hFF;
            hi_q      <= 8'h00;
            snap_q    <= 8'h00;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            rd_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cat_q     <= cat_d;
            hi_q      <= hi_d;
            snap_q    <= snap_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            rd_prev_q <= fifo.rx_rd;
        end
    end
endmodule
